// File: rtl/add_result_fifo_if.sv
// Valid/ready handshake bundle for the add/select result FIFO: producer side (in_*) and consumer side (out_*).
// The master modport is the environment that drives the producer and consumer; the slave modport is the FIFO.
interface add_result_fifo_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic             in_co;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_co;

  modport master (
    output in_valid, in_sum, in_co, out_ready,
    input  in_ready, out_valid, out_sum, out_co
  );

  modport slave (
    input  in_valid, in_sum, in_co, out_ready,
    output in_ready, out_valid, out_sum, out_co
  );
endinterface

// File: rtl/add_result_fifo.sv
// First-word-fall-through capture FIFO for {CO,SUM} adder results with valid/ready handshakes on both sides.
// Optional saturating carry-out event counter enabled by defining ADD_RESULT_FIFO_CARRY_CNT_EN.
module add_result_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  add_result_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       carry_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic             co;
    logic [WIDTH-1:0] sum;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             push;
  logic             pop;

  // in_ready is decoded from registered occupancy and rst only, so out_ready never reaches it.
  assign bus.in_ready  = !rst && (level_q != LVL_W'(DEPTH));
  assign bus.out_valid = (level_q != '0);

  assign push = bus.in_valid  & bus.in_ready;
  assign pop  = bus.out_valid & bus.out_ready;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // NOTE: storage is deliberately not reset; stale words are never visible because the output is masked.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{co: bus.in_co, sum: bus.in_sum};
  end

  assign head        = mem_q[rd_ptr_q];
  assign bus.out_sum = bus.out_valid ? head.sum : '0;
  assign bus.out_co  = bus.out_valid ? head.co  : 1'b0;
  assign level       = level_q;

`ifdef ADD_RESULT_FIFO_CARRY_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && bus.in_co && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign carry_cnt = cnt_q;
`else
  assign carry_cnt = '0;
`endif

  occupancy_bounded: assert property (@(posedge clk) disable iff (rst) level_q <= LVL_W'(DEPTH));

endmodule

// File: tb/tb_add_result_fifo.sv
// Scoreboard bench for add_result_fifo: the driver queues expected results, a negedge monitor checks every pop.
// Expected carry_cnt follows ADD_RESULT_FIFO_CARRY_CNT_EN (CNT_W=2, so it saturates at 3).
module tb_add_result_fifo;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  typedef struct packed {
    logic             co;
    logic [WIDTH-1:0] sum;
  } exp_t;

  logic                   clk;
  logic                   rst;
  logic [$clog2(DEPTH):0] level;
  logic [CNT_W-1:0]       carry_cnt;

  add_result_fifo_if #(.WIDTH(WIDTH)) bus ();

  add_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .level     (level),
    .carry_cnt (carry_cnt)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];
  int   exp_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pop the DUT performs must match the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", 32'(bus.out_sum), 32'hDEAD);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pop_sum", 32'(bus.out_sum), 32'(e.sum));
        check("pop_co",  32'(bus.out_co),  32'(e.co));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents one result for a cycle; in_valid stays high until set_idle().
  task automatic push(input logic [WIDTH-1:0] sum, input logic co, input bit accept);
    bus.in_valid = 1'b1;
    bus.in_sum   = sum;
    bus.in_co    = co;
    @(negedge clk);
    check("in_ready", 32'(bus.in_ready), 32'(accept));
    check("carry_cnt", 32'(carry_cnt), 32'(exp_cnt));
    if (accept) begin
      sb.push_back('{co: co, sum: sum});
`ifdef ADD_RESULT_FIFO_CARRY_CNT_EN
      if (co && exp_cnt < (2**CNT_W - 1)) exp_cnt++;
`endif
    end
    next_cycle();
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    sb.delete();
    exp_cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      check("rst_in_ready", 32'(bus.in_ready), 32'd0);
      next_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sum    = '0;
    bus.in_co     = 1'b0;
    bus.out_ready = 1'b0;

    // 1: reset then idle
    do_reset(2);
    @(negedge clk);
    check("idle_in_ready",  32'(bus.in_ready),  32'd1);
    check("idle_level",     32'(level),         32'd0);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_out_sum",   32'(bus.out_sum),   32'd0);
    check("idle_out_co",    32'(bus.out_co),    32'd0);
    check("idle_carry_cnt", 32'(carry_cnt),     32'd0);
    next_cycle();

    // 2: stall with three entries, then drain in order
    push(4'h3, 1'b0, 1'b1);
    push(4'hF, 1'b1, 1'b1);
    push(4'h8, 1'b0, 1'b1);
    set_idle();
    repeat (2) begin
      @(negedge clk);
      check("stall_level",   32'(level),       32'd3);
      check("stall_out_sum", 32'(bus.out_sum), 32'h3);
      check("stall_out_co",  32'(bus.out_co),  32'd0);
      next_cycle();
    end
    bus.out_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("drain_level",     32'(level),         32'd0);
    check("drain_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    next_cycle();

    // 3: fill to DEPTH, rejected push, in_ready rises only after the pop
    push(4'h1, 1'b0, 1'b1);
    push(4'h2, 1'b1, 1'b1);
    push(4'h3, 1'b0, 1'b1);
    push(4'h4, 1'b0, 1'b1);
    push(4'hA, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("full_level",            32'(level),        32'd4);
    check("full_pop_same_cycle",   32'(bus.in_ready), 32'd0);
    next_cycle();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("after_pop_in_ready", 32'(bus.in_ready), 32'd1);
    check("after_pop_level",    32'(level),        32'd3);
    sb.push_back('{co: 1'b0, sum: 4'hA});
    next_cycle();
    set_idle();
    @(negedge clk);
    check("refill_level", 32'(level), 32'd4);
    bus.out_ready = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    check("fill_drain_level", 32'(level), 32'd0);
    next_cycle();

    // 4: streaming 0..9 with the consumer always ready
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sum   = 4'(i);
      bus.in_co    = 1'(i);
      @(negedge clk);
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      check("stream_level",    32'(level),        (i == 0) ? 32'd0 : 32'd1);
      if (i > 0) check("stream_lag", 32'(bus.out_sum), 32'(i - 1));
      sb.push_back('{co: 1'(i), sum: 4'(i)});
`ifdef ADD_RESULT_FIFO_CARRY_CNT_EN
      if (i % 2 == 1 && exp_cnt < (2**CNT_W - 1)) exp_cnt++;
`endif
      next_cycle();
    end
    set_idle();
    next_cycle();
    @(negedge clk);
    check("stream_end_level", 32'(level), 32'd0);
    bus.out_ready = 1'b0;
    next_cycle();

    // 5: reset with three queued entries; push during reset is cancelled
    push(4'h1, 1'b0, 1'b1);
    push(4'h2, 1'b0, 1'b1);
    push(4'h3, 1'b0, 1'b1);
    @(negedge clk);
    check("pre_rst_level", 32'(level), 32'd3);
    next_cycle();
    bus.in_valid = 1'b1;
    bus.in_sum   = 4'h7;
    bus.in_co    = 1'b1;
    do_reset(1);
    set_idle();
    @(negedge clk);
    check("post_rst_level",     32'(level),         32'd0);
    check("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("post_rst_out_sum",   32'(bus.out_sum),   32'd0);
    check("post_rst_carry_cnt", 32'(carry_cnt),     32'd0);
    next_cycle();
    push(4'h5, 1'b1, 1'b1);
    set_idle();
    @(negedge clk);
    check("first_after_rst", 32'(bus.out_sum), 32'h5);
    bus.out_ready = 1'b1;
    next_cycle();
    @(negedge clk);
    check("first_after_rst_level", 32'(level), 32'd0);
    next_cycle();

    // 6: five carry-out results; counter saturates at 2^CNT_W-1 when enabled
    do_reset(1);
    for (int i = 0; i < 5; i++) push(4'(i + 8), 1'b1, 1'b1);
    set_idle();
    @(negedge clk);
    check("carry_cnt_final", 32'(carry_cnt), 32'(exp_cnt));
    next_cycle();
    repeat (2) next_cycle();
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("end_level",    32'(level),    32'd0);
    check("sb_empty",     32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
